// File: rtl/axi_ddr3_arb2_pkg.sv
// -----------------------------------------------------------------------------
// axi_ddr3_arb2_pkg
// Shared definitions for the two-port AXI4 arbiter in front of the DDR3
// controller: AXI encodings, the arbiter state type and the position of the
// master-index tag bit inside the controller-side ID.
// -----------------------------------------------------------------------------
package axi_ddr3_arb2_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  // The master index is prepended above the per-master ID, so it lands on
  // bit SID_WIDTH of the controller-side ID.
  function automatic int id_tag_pos(input int sid_width);
    return sid_width;
  endfunction

endpackage

// File: rtl/axi_arb_rr2.sv
// -----------------------------------------------------------------------------
// axi_arb_rr2
// Two-way round-robin arbiter with handshake lock, used for the AW and AR
// channels. Grant is combinational from the requests while idle; once the
// downstream stalls the choice is held until its handshake completes.
//
// Ports:
//   clock, reset_n  clock and synchronous active-low reset
//   req[1:0]        request from master 0 / master 1 (already qualified)
//   ready           downstream ready
//   grant_valid     a request is being presented downstream
//   grant_idx       index of the master being presented
//   handshake       grant_valid & ready this cycle
// -----------------------------------------------------------------------------
module axi_arb_rr2
  import axi_ddr3_arb2_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       ready,
  output logic       grant_valid,
  output logic       grant_idx,
  output logic       handshake
);

  arb_state_t state_q, state_d;
  logic       sel_q, sel_d;
  logic       last_q, last_d;

  // State register. last resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours regardless of evaluation order.
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  // Output / grant selection.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned and infers a latch.
    grant_idx   = 1'b0;
    grant_valid = 1'b0;
    if (state_q == ARB_LOCK) begin
      grant_idx   = sel_q;
      grant_valid = req[sel_q];
    end else begin
      grant_valid = |req;
      case (req)
        2'b10:   grant_idx = 1'b1;
        2'b11:   grant_idx = ~last_q;
        default: grant_idx = 1'b0;
      endcase
    end
    handshake = grant_valid & ready;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (handshake) last_d = grant_idx;
    case (state_q)
      ARB_IDLE: begin
        if (grant_valid && !ready) begin
          state_d = ARB_LOCK;
          sel_d   = grant_idx;
        end
      end
      default: begin
        if (handshake) state_d = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/axi_ddr3_arb2.sv
// -----------------------------------------------------------------------------
// axi_ddr3_arb2
// Lets two AXI4 masters (s0, s1) share the single controller port (m).
//   AW/AR : independent round-robin arbiters with lock; zero-latency mux;
//           the master index is prepended to the ID.
//   W     : steered by an in-order FIFO of AW grant indices; the head entry
//           owns the W channel until its wlast beat.
//   B/R   : routed combinationally by the tag bit of m_bid / m_rid.
// Payload outputs read as zero whenever their valid is low, and every
// valid/ready output is forced low while reset_n is asserted.
// -----------------------------------------------------------------------------
module axi_ddr3_arb2
  import axi_ddr3_arb2_pkg::*;
#(
  parameter int ADDRS     = 29,
  parameter int WIDTH     = 32,
  parameter int MASKS     = 4,
  parameter int SID_WIDTH = 3,
  parameter int WRQ_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  // master 0
  input  logic                 s0_awvalid,
  output logic                 s0_awready,
  input  logic [ADDRS-1:0]     s0_awaddr,
  input  logic [SID_WIDTH-1:0] s0_awid,
  input  logic [7:0]           s0_awlen,
  input  logic [1:0]           s0_awburst,
  input  logic                 s0_wvalid,
  output logic                 s0_wready,
  input  logic                 s0_wlast,
  input  logic [MASKS-1:0]     s0_wstrb,
  input  logic [WIDTH-1:0]     s0_wdata,
  output logic                 s0_bvalid,
  input  logic                 s0_bready,
  output logic [1:0]           s0_bresp,
  output logic [SID_WIDTH-1:0] s0_bid,
  input  logic                 s0_arvalid,
  output logic                 s0_arready,
  input  logic [ADDRS-1:0]     s0_araddr,
  input  logic [SID_WIDTH-1:0] s0_arid,
  input  logic [7:0]           s0_arlen,
  input  logic [1:0]           s0_arburst,
  output logic                 s0_rvalid,
  input  logic                 s0_rready,
  output logic                 s0_rlast,
  output logic [1:0]           s0_rresp,
  output logic [SID_WIDTH-1:0] s0_rid,
  output logic [WIDTH-1:0]     s0_rdata,
  // master 1
  input  logic                 s1_awvalid,
  output logic                 s1_awready,
  input  logic [ADDRS-1:0]     s1_awaddr,
  input  logic [SID_WIDTH-1:0] s1_awid,
  input  logic [7:0]           s1_awlen,
  input  logic [1:0]           s1_awburst,
  input  logic                 s1_wvalid,
  output logic                 s1_wready,
  input  logic                 s1_wlast,
  input  logic [MASKS-1:0]     s1_wstrb,
  input  logic [WIDTH-1:0]     s1_wdata,
  output logic                 s1_bvalid,
  input  logic                 s1_bready,
  output logic [1:0]           s1_bresp,
  output logic [SID_WIDTH-1:0] s1_bid,
  input  logic                 s1_arvalid,
  output logic                 s1_arready,
  input  logic [ADDRS-1:0]     s1_araddr,
  input  logic [SID_WIDTH-1:0] s1_arid,
  input  logic [7:0]           s1_arlen,
  input  logic [1:0]           s1_arburst,
  output logic                 s1_rvalid,
  input  logic                 s1_rready,
  output logic                 s1_rlast,
  output logic [1:0]           s1_rresp,
  output logic [SID_WIDTH-1:0] s1_rid,
  output logic [WIDTH-1:0]     s1_rdata,
  // controller port
  output logic                 m_awvalid,
  input  logic                 m_awready,
  output logic [ADDRS-1:0]     m_awaddr,
  output logic [SID_WIDTH:0]   m_awid,
  output logic [7:0]           m_awlen,
  output logic [1:0]           m_awburst,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  output logic                 m_wlast,
  output logic [MASKS-1:0]     m_wstrb,
  output logic [WIDTH-1:0]     m_wdata,
  input  logic                 m_bvalid,
  output logic                 m_bready,
  input  logic [1:0]           m_bresp,
  input  logic [SID_WIDTH:0]   m_bid,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  output logic [ADDRS-1:0]     m_araddr,
  output logic [SID_WIDTH:0]   m_arid,
  output logic [7:0]           m_arlen,
  output logic [1:0]           m_arburst,
  input  logic                 m_rvalid,
  output logic                 m_rready,
  input  logic                 m_rlast,
  input  logic [1:0]           m_rresp,
  input  logic [SID_WIDTH:0]   m_rid,
  input  logic [WIDTH-1:0]     m_rdata
);

  localparam int TAG   = id_tag_pos(SID_WIDTH);
  localparam int PTR_W = $clog2(WRQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // Write-order FIFO state (declared early: full gates the AW arbiter)
  // ---------------------------------------------------------------------------
  logic             wq_mem [WRQ_DEPTH];
  logic [PTR_W-1:0] wq_wr, wq_rd;
  logic [CNT_W-1:0] wq_count;
  logic             wq_full, wq_empty, wq_push, wq_pop;

  // full comes straight from the registered count, so a same-cycle pop
  // never opens a slot for a new AW.
  assign wq_full  = (wq_count == CNT_W'(WRQ_DEPTH));
  assign wq_empty = (wq_count == '0);

  // ---------------------------------------------------------------------------
  // AW channel
  // ---------------------------------------------------------------------------
  logic [1:0] aw_req;
  logic       aw_valid, aw_sel, aw_hs;

  assign aw_req = {s1_awvalid, s0_awvalid} & {2{reset_n & ~wq_full}};

  axi_arb_rr2 u_aw_arb (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (aw_req),
    .ready       (m_awready),
    .grant_valid (aw_valid),
    .grant_idx   (aw_sel),
    .handshake   (aw_hs)
  );

  assign m_awvalid  = aw_valid;
  assign m_awaddr   = aw_valid ? (aw_sel ? s1_awaddr  : s0_awaddr)  : '0;
  assign m_awlen    = aw_valid ? (aw_sel ? s1_awlen   : s0_awlen)   : '0;
  assign m_awburst  = aw_valid ? (aw_sel ? s1_awburst : s0_awburst) : '0;
  assign m_awid     = aw_valid ? {aw_sel, (aw_sel ? s1_awid : s0_awid)} : '0;
  assign s0_awready = aw_valid & ~aw_sel & m_awready;
  assign s1_awready = aw_valid &  aw_sel & m_awready;

  // ---------------------------------------------------------------------------
  // AR channel
  // ---------------------------------------------------------------------------
  logic [1:0] ar_req;
  logic       ar_valid, ar_sel, ar_hs;

  assign ar_req = {s1_arvalid, s0_arvalid} & {2{reset_n}};

  axi_arb_rr2 u_ar_arb (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (ar_req),
    .ready       (m_arready),
    .grant_valid (ar_valid),
    .grant_idx   (ar_sel),
    .handshake   (ar_hs)
  );

  assign m_arvalid  = ar_valid;
  assign m_araddr   = ar_valid ? (ar_sel ? s1_araddr  : s0_araddr)  : '0;
  assign m_arlen    = ar_valid ? (ar_sel ? s1_arlen   : s0_arlen)   : '0;
  assign m_arburst  = ar_valid ? (ar_sel ? s1_arburst : s0_arburst) : '0;
  assign m_arid     = ar_valid ? {ar_sel, (ar_sel ? s1_arid : s0_arid)} : '0;
  assign s0_arready = ar_valid & ~ar_sel & m_arready;
  assign s1_arready = ar_valid &  ar_sel & m_arready;

  // ---------------------------------------------------------------------------
  // Write-order FIFO
  // ---------------------------------------------------------------------------
  logic w_head, w_open;

  assign wq_push = aw_hs;
  assign wq_pop  = m_wvalid & m_wready & m_wlast;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wq_wr    <= '0;
      wq_rd    <= '0;
      wq_count <= '0;
    end else begin
      if (wq_push) wq_wr <= wq_wr + 1'b1;
      if (wq_pop)  wq_rd <= wq_rd + 1'b1;
      case ({wq_push, wq_pop})
        2'b10:   wq_count <= wq_count + 1'b1;
        2'b01:   wq_count <= wq_count - 1'b1;
        default: wq_count <= wq_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by the
  // pointers and count, so clearing the cells would only add reset fan-out.
  always_ff @(posedge clock) begin
    if (wq_push) wq_mem[wq_wr] <= aw_sel;
  end

  // ---------------------------------------------------------------------------
  // W channel: the FIFO head owns the channel until its wlast beat.
  // ---------------------------------------------------------------------------
  assign w_head = wq_mem[wq_rd];
  assign w_open = reset_n & ~wq_empty;

  assign m_wvalid  = w_open & (w_head ? s1_wvalid : s0_wvalid);
  assign m_wlast   = m_wvalid & (w_head ? s1_wlast : s0_wlast);
  assign m_wstrb   = m_wvalid ? (w_head ? s1_wstrb : s0_wstrb) : '0;
  assign m_wdata   = m_wvalid ? (w_head ? s1_wdata : s0_wdata) : '0;
  assign s0_wready = w_open & ~w_head & m_wready;
  assign s1_wready = w_open &  w_head & m_wready;

  // ---------------------------------------------------------------------------
  // B and R routing by ID tag bit
  // ---------------------------------------------------------------------------
  logic b_tag, r_tag;

  assign b_tag = m_bid[TAG];
  assign r_tag = m_rid[TAG];

  assign s0_bvalid = reset_n & m_bvalid & ~b_tag;
  assign s1_bvalid = reset_n & m_bvalid &  b_tag;
  assign s0_bid    = s0_bvalid ? m_bid[SID_WIDTH-1:0] : '0;
  assign s1_bid    = s1_bvalid ? m_bid[SID_WIDTH-1:0] : '0;
  assign s0_bresp  = s0_bvalid ? m_bresp : RESP_OKAY;
  assign s1_bresp  = s1_bvalid ? m_bresp : RESP_OKAY;
  assign m_bready  = reset_n & m_bvalid & (b_tag ? s1_bready : s0_bready);

  assign s0_rvalid = reset_n & m_rvalid & ~r_tag;
  assign s1_rvalid = reset_n & m_rvalid &  r_tag;
  assign s0_rid    = s0_rvalid ? m_rid[SID_WIDTH-1:0] : '0;
  assign s1_rid    = s1_rvalid ? m_rid[SID_WIDTH-1:0] : '0;
  assign s0_rresp  = s0_rvalid ? m_rresp : RESP_OKAY;
  assign s1_rresp  = s1_rvalid ? m_rresp : RESP_OKAY;
  assign s0_rlast  = s0_rvalid & m_rlast;
  assign s1_rlast  = s1_rvalid & m_rlast;
  assign s0_rdata  = s0_rvalid ? m_rdata : '0;
  assign s1_rdata  = s1_rvalid ? m_rdata : '0;
  assign m_rready  = reset_n & m_rvalid & (r_tag ? s1_rready : s0_rready);

endmodule

// File: tb/tb_axi_ddr3_arb2.sv
// -----------------------------------------------------------------------------
// tb_axi_ddr3_arb2
// Directed scenarios plus a randomized AR stream and randomized response
// routing, checked against expectations computed from the arbiter's rules.
// -----------------------------------------------------------------------------
module tb_axi_ddr3_arb2;
  import axi_ddr3_arb2_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        s0_awvalid, s0_awready, s1_awvalid, s1_awready;
  logic [28:0] s0_awaddr, s1_awaddr, s0_araddr, s1_araddr, m_awaddr, m_araddr;
  logic [2:0]  s0_awid, s1_awid, s0_arid, s1_arid, s0_bid, s1_bid, s0_rid, s1_rid;
  logic [7:0]  s0_awlen, s1_awlen, s0_arlen, s1_arlen, m_awlen, m_arlen;
  logic [1:0]  s0_awburst, s1_awburst, s0_arburst, s1_arburst, m_awburst, m_arburst;
  logic        s0_wvalid, s0_wready, s0_wlast, s1_wvalid, s1_wready, s1_wlast;
  logic [3:0]  s0_wstrb, s1_wstrb, m_wstrb;
  logic [31:0] s0_wdata, s1_wdata, m_wdata, s0_rdata, s1_rdata, m_rdata;
  logic        s0_bvalid, s0_bready, s1_bvalid, s1_bready;
  logic [1:0]  s0_bresp, s1_bresp, m_bresp, s0_rresp, s1_rresp, m_rresp;
  logic        s0_arvalid, s0_arready, s1_arvalid, s1_arready;
  logic        s0_rvalid, s0_rready, s0_rlast, s1_rvalid, s1_rready, s1_rlast;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [3:0]  m_awid, m_bid, m_arid, m_rid;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  axi_ddr3_arb2 dut (
    .clock(clock), .reset_n(reset_n),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awaddr(s0_awaddr),
    .s0_awid(s0_awid), .s0_awlen(s0_awlen), .s0_awburst(s0_awburst),
    .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_wlast(s0_wlast),
    .s0_wstrb(s0_wstrb), .s0_wdata(s0_wdata),
    .s0_bvalid(s0_bvalid), .s0_bready(s0_bready), .s0_bresp(s0_bresp), .s0_bid(s0_bid),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
    .s0_arid(s0_arid), .s0_arlen(s0_arlen), .s0_arburst(s0_arburst),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rlast(s0_rlast),
    .s0_rresp(s0_rresp), .s0_rid(s0_rid), .s0_rdata(s0_rdata),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awaddr(s1_awaddr),
    .s1_awid(s1_awid), .s1_awlen(s1_awlen), .s1_awburst(s1_awburst),
    .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_wlast(s1_wlast),
    .s1_wstrb(s1_wstrb), .s1_wdata(s1_wdata),
    .s1_bvalid(s1_bvalid), .s1_bready(s1_bready), .s1_bresp(s1_bresp), .s1_bid(s1_bid),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
    .s1_arid(s1_arid), .s1_arlen(s1_arlen), .s1_arburst(s1_arburst),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rlast(s1_rlast),
    .s1_rresp(s1_rresp), .s1_rid(s1_rid), .s1_rdata(s1_rdata),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awid(m_awid), .m_awlen(m_awlen), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
    .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arid(m_arid), .m_arlen(m_arlen), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast),
    .m_rresp(m_rresp), .m_rid(m_rid), .m_rdata(m_rdata)
  );

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    {s0_awvalid, s1_awvalid, s0_wvalid, s1_wvalid, s0_arvalid, s1_arvalid} = '0;
    {s0_wlast, s1_wlast, s0_bready, s1_bready, s0_rready, s1_rready} = '0;
    s0_awaddr = '0; s1_awaddr = '0; s0_araddr = '0; s1_araddr = '0;
    s0_awid = '0; s1_awid = '0; s0_arid = '0; s1_arid = '0;
    s0_awlen = '0; s1_awlen = '0; s0_arlen = '0; s1_arlen = '0;
    s0_awburst = BURST_INCR; s1_awburst = BURST_INCR;
    s0_arburst = BURST_INCR; s1_arburst = BURST_INCR;
    s0_wstrb = '0; s1_wstrb = '0; s0_wdata = '0; s1_wdata = '0;
    {m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_rlast} = '0;
    m_bresp = RESP_OKAY; m_rresp = RESP_OKAY;
    m_bid = '0; m_rid = '0; m_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_valids"}, {m_awvalid, m_wvalid, m_arvalid, s0_bvalid, s1_bvalid,
                            s0_rvalid, s1_rvalid}, 0);
    check({tag, "_readys"}, {s0_awready, s1_awready, s0_wready, s1_wready, s0_arready,
                            s1_arready, m_bready, m_rready}, 0);
  endtask

  // Random-stream model data
  logic [28:0] q_addr [2][8];
  logic [2:0]  q_id   [2][8];
  logic        exp_src [13];
  logic [28:0] exp_addr [13];
  logic [2:0]  exp_id   [13];
  int          n_req [2];
  int          taken [2];
  int          ptr   [2];
  int          turn, src, k, budget;
  logic [28:0] a0, a1;
  logic [2:0]  id0, id1;
  logic [31:0] d0, beat;
  logic [3:0]  rid, bid;

  initial begin
    // ---------------- Reset state ----------------
    do_reset();
    s0_awaddr = 29'h1abc; s1_araddr = 29'h0555; s0_wdata = 32'hdeadbeef;
    settle();
    check_all_quiet("reset");
    check("reset_payload", {m_awaddr, m_araddr, m_wdata, m_awid, m_arid}, 0);

    // ---------------- Tie on AW ----------------
    do_reset();
    a0 = $urandom; a1 = $urandom; id0 = $urandom; id1 = $urandom;
    s0_awvalid = 1; s0_awaddr = a0; s0_awid = id0; s0_awlen = 8'd2;
    s1_awvalid = 1; s1_awaddr = a1; s1_awid = id1; s1_awlen = 8'd5;
    m_awready = 1;
    settle();
    check("tie_first_id", m_awid, {1'b0, id0});
    check("tie_first_addr", m_awaddr, a0);
    check("tie_first_len_burst", {m_awlen, m_awburst}, {8'd2, BURST_INCR});
    check("tie_first_readys", {s0_awready, s1_awready}, 2'b10);
    tick();
    s0_awvalid = 0;
    settle();
    check("tie_second_id", m_awid, {1'b1, id1});
    check("tie_second_addr", m_awaddr, a1);
    check("tie_second_readys", {s0_awready, s1_awready}, 2'b01);
    tick();

    // ---------------- Lock under backpressure (AR) ----------------
    do_reset();
    a0 = $urandom; a1 = $urandom; id0 = $urandom; id1 = $urandom;
    s1_arvalid = 1; s1_araddr = a1; s1_arid = id1;
    settle();
    check("lock_s1_addr", m_araddr, a1);
    tick();
    s0_arvalid = 1; s0_araddr = a0; s0_arid = id0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("lock_hold_addr", m_araddr, a1);
      check("lock_hold_readys", {s0_arready, s1_arready}, 2'b00);
      tick();
    end
    m_arready = 1;
    settle();
    check("lock_release_id", m_arid, {1'b1, id1});
    check("lock_release_readys", {s0_arready, s1_arready}, 2'b01);
    tick();
    s1_arvalid = 0;
    settle();
    check("lock_next_addr", m_araddr, a0);
    check("lock_next_readys", {s0_arready, s1_arready}, 2'b10);
    tick();
    s0_arvalid = 0;

    // ---------------- Write-data ordering ----------------
    do_reset();
    m_awready = 1; m_wready = 1;
    d0 = $urandom;
    s1_awvalid = 1; s1_awlen = 8'd3; s1_awid = 3'd5;
    s0_wvalid = 1; s0_wlast = 1; s0_wdata = d0; s0_wstrb = 4'hf;
    settle();
    check("word_empty_wvalid", m_wvalid, 0);
    check("word_empty_wready", {s0_wready, s1_wready}, 2'b00);
    tick();
    s1_awvalid = 0;
    s0_awvalid = 1; s0_awlen = 8'd0;
    settle();
    check("word_s0_aw_ready", s0_awready, 1);
    check("word_s0_blocked", {s0_wready, m_wvalid}, 2'b00);
    tick();
    s0_awvalid = 0;
    for (int i = 0; i < 4; i++) begin
      beat = $urandom;
      s1_wvalid = 1; s1_wdata = beat; s1_wstrb = 4'(i + 1); s1_wlast = (i == 3);
      settle();
      check("word_s1_beat_data", m_wdata, beat);
      check("word_s1_beat_ctl", {m_wvalid, m_wlast, m_wstrb}, {1'b1, i == 3, 4'(i + 1)});
      check("word_s1_beat_readys", {s0_wready, s1_wready}, 2'b01);
      tick();
    end
    s1_wvalid = 0; s1_wlast = 0;
    settle();
    check("word_s0_beat_data", m_wdata, d0);
    check("word_s0_beat_ctl", {m_wvalid, m_wlast, s0_wready, s1_wready}, 4'b1110);
    tick();
    s0_wvalid = 0;
    settle();
    check("word_drained", m_wvalid, 0);

    // ---------------- FIFO full ----------------
    do_reset();
    m_awready = 1;
    s0_awvalid = 1; s0_awlen = 8'd0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("full_accept", s0_awready, 1);
      tick();
    end
    settle();
    check("full_blocked", {m_awvalid, s0_awready}, 2'b00);
    s0_wvalid = 1; s0_wlast = 1; m_wready = 1;
    settle();
    check("full_pop_cycle_w", m_wvalid, 1);
    check("full_pop_same_cycle", {m_awvalid, s0_awready}, 2'b00);
    tick();
    s0_wvalid = 0;
    settle();
    check("full_relieved", {m_awvalid, s0_awready}, 2'b11);
    tick();
    s0_awvalid = 0;

    // ---------------- Response routing ----------------
    do_reset();
    m_rvalid = 1; m_rid = 4'b1010; m_rdata = $urandom; s1_rready = 1;
    m_bvalid = 1; m_bid = 4'b0011; s0_bready = 1;
    settle();
    check("route_r_valids", {s0_rvalid, s1_rvalid}, 2'b01);
    check("route_r_id", s1_rid, 3'b010);
    check("route_r_data", s1_rdata, m_rdata);
    check("route_b_id", s0_bid, 3'b011);
    check("route_b_valids", {s0_bvalid, s1_bvalid, m_bready}, 3'b101);
    for (int i = 0; i < 16; i++) begin
      rid = 4'($urandom); bid = 4'($urandom);
      m_rid = rid; m_bid = bid; m_rdata = $urandom; m_rresp = 2'($urandom);
      m_rlast = 1'($urandom); m_bresp = 2'($urandom);
      {s0_rready, s1_rready, s0_bready, s1_bready} = 4'($urandom);
      settle();
      if (rid[3]) begin
        check("rr_s1", {s1_rvalid, s1_rid, s1_rresp, s1_rlast, s0_rvalid},
              {1'b1, rid[2:0], m_rresp, m_rlast, 1'b0});
        check("rr_s1_data", s1_rdata, m_rdata);
        check("rr_s1_ready", m_rready, s1_rready);
      end else begin
        check("rr_s0", {s0_rvalid, s0_rid, s0_rresp, s0_rlast, s1_rvalid},
              {1'b1, rid[2:0], m_rresp, m_rlast, 1'b0});
        check("rr_s0_data", s0_rdata, m_rdata);
        check("rr_s0_ready", m_rready, s0_rready);
      end
      if (bid[3]) begin
        check("rb_s1", {s1_bvalid, s1_bid, s1_bresp, s0_bvalid, m_bready},
              {1'b1, bid[2:0], m_bresp, 1'b0, s1_bready});
      end else begin
        check("rb_s0", {s0_bvalid, s0_bid, s0_bresp, s1_bvalid, m_bready},
              {1'b1, bid[2:0], m_bresp, 1'b0, s0_bready});
      end
      tick();
    end

    // ---------------- Randomized AR stream vs round-robin model ----------------
    do_reset();
    n_req[0] = 8; n_req[1] = 5;
    for (int m = 0; m < 2; m++)
      for (int j = 0; j < 8; j++) begin
        q_addr[m][j] = 29'($urandom);
        q_id[m][j]   = 3'($urandom);
      end
    // With both masters always requesting, grants alternate starting at s0;
    // once one master runs dry the other takes the remaining slots.
    taken[0] = 0; taken[1] = 0; turn = 0;
    for (int j = 0; j < 13; j++) begin
      if (taken[0] < n_req[0] && taken[1] < n_req[1]) begin
        src = turn;
        turn = 1 - turn;
      end else begin
        src = (taken[0] < n_req[0]) ? 0 : 1;
      end
      exp_src[j]  = 1'(src);
      exp_addr[j] = q_addr[src][taken[src]];
      exp_id[j]   = q_id[src][taken[src]];
      taken[src]++;
    end
    ptr[0] = 0; ptr[1] = 0; k = 0; budget = 0;
    while (k < 13 && budget < 300) begin
      s0_arvalid = (ptr[0] < n_req[0]);
      s1_arvalid = (ptr[1] < n_req[1]);
      if (ptr[0] < n_req[0]) begin s0_araddr = q_addr[0][ptr[0]]; s0_arid = q_id[0][ptr[0]]; end
      if (ptr[1] < n_req[1]) begin s1_araddr = q_addr[1][ptr[1]]; s1_arid = q_id[1][ptr[1]]; end
      m_arready = 1'($urandom);
      settle();
      check("stream_valid", m_arvalid, 1);
      check("stream_addr", m_araddr, exp_addr[k]);
      check("stream_id", m_arid, {exp_src[k], exp_id[k]});
      check("stream_readys", {s0_arready, s1_arready},
            {m_arready & (exp_src[k] == 1'b0), m_arready & (exp_src[k] == 1'b1)});
      if (m_arready) begin
        ptr[exp_src[k]]++;
        k++;
      end
      tick();
      budget++;
    end
    check("stream_done", k, 13);
    s0_arvalid = 0; s1_arvalid = 0; m_arready = 0;

    // ---------------- Reset mid-burst ----------------
    do_reset();
    m_awready = 1; m_wready = 1;
    s1_awvalid = 1; s1_awlen = 8'd3;
    tick();
    s1_awvalid = 0;
    s1_wvalid = 1; s1_wdata = $urandom;
    settle();
    check("midrst_beat_pass", {m_wvalid, s1_wready}, 2'b11);
    tick();
    s0_awvalid = 1; s0_arvalid = 1; m_arready = 1;
    reset_n = 0;
    tick();
    settle();
    check_all_quiet("midrst_in_reset");
    reset_n = 1;
    s0_awvalid = 0; s0_arvalid = 0;
    settle();
    check("midrst_fifo_empty", {m_wvalid, s1_wready, s0_wready}, 3'b000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
